hack_rom_loader: RTL and testbench
==================================

// Module: hack_rom_loader
// PURPOSE
//   Byte-stream program loader: write-side counterpart of the instruction ROM.
//   Accepts bytes from a UART/host byte source over a valid/ready handshake.
//   Assembles big-endian 16-bit Hack instructions and writes them to the instruction memory write port.
//   Holds the CPU in reset while loading, then releases it when loading finishes.
// PARAMETERS
//   ADDR_WIDTH      12           instruction memory depth = 2**ADDR_WIDTH words
//   TIMEOUT_CYCLES  100_000_000  max clk cycles between accepted bytes before error (>=2)
// PORTS
//   clk           in   1            system clock; all logic on rising edge
//   rst           in   1            asynchronous, active-high reset
//   start         in   1            1-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
//   rx_data       in   8            incoming byte
//   rx_valid      in   1            rx_data valid
//   rx_ready      out  1            loader accepts byte this cycle (accept = rx_valid & rx_ready)
//   wr_en         out  1            instruction memory write strobe, 1 cycle per word
//   wr_addr       out  15           word address (upper bits above ADDR_WIDTH are 0)
//   wr_data       out  16           instruction word
//   cpu_reset     out  1            hold CPU in reset
//   busy          out  1            load in progress
//   done          out  1            last load completed OK (level, cleared by start)
//   error         out  1            last load failed (level, cleared by start)
//   words_loaded  out  ADDR_WIDTH+1 count of words written in the current/last load
// BEHAVIOUR
//   Reset: state=IDLE; rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=0, busy=0, done=0, error=0, words_loaded=0.
//     cpu_reset=0 in IDLE lets a preloaded image run.
//   Stream format: LEN_HI, LEN_LO (N = word count), then N words as HI byte then LO byte.
//   States: IDLE, LEN_HI, LEN_LO, D_HI, D_LO, WRITE, [CK_HI, CK_LO], DONE, ERR.
//   start (IDLE/DONE/ERR) -> LEN_HI: clear done/error/words_loaded/index/sum; busy=1, cpu_reset=1.
//   start while busy is ignored.
//   rx_ready=1 in LEN_HI, LEN_LO, D_HI, D_LO, CK_HI, CK_LO; 0 in all other states.
//   Each accepted byte advances exactly one state. No byte is accepted in WRITE.
//   After LEN_LO:
//     N==0 -> DONE with no writes.
//     N>2**ADDR_WIDTH -> ERR with no writes.
//     Otherwise -> D_HI.
//   D_LO accept -> WRITE. WRITE lasts 1 cycle: wr_en=1, wr_addr=index, wr_data={hi,lo}.
//     words_loaded increments the same cycle and index then increments.
//     Latency: wr_en is asserted the cycle after the LO byte is accepted.
//   WRITE -> D_HI if words_loaded<N, else end-of-data.
//   Index wraps only if N=2**ADDR_WIDTH is reached; this is the last word, so no overrun.
//   Timeout: counter runs in byte-accepting states and clears on each accepted byte and on state entry.
//     Reaching TIMEOUT_CYCLES -> ERR.
//   DONE: busy=0, done=1, cpu_reset=0 (CPU restarts at PC 0).
//   ERR: busy=0, error=1, cpu_reset=1 (a partial image never executes).
//   rst mid-load: immediate return to reset values. Words already written remain in memory.
// CONFIGURATION
//   HACK_LOADER_CHECKSUM_EN defined:
//     End-of-data -> CK_HI, CK_LO: receive 16-bit big-endian checksum.
//     Checksum = modulo-2^16 sum of all data words.
//     Match -> DONE; mismatch -> ERR. For N==0 the checksum is still expected (must be 0x0000).
//   Not defined: end-of-data -> DONE directly; CK states absent; error only from length/timeout.
// TESTING
//   Load 00 02 | 12 34 | AB CD (plus checksum BE 01 if EN):
//     -> wr(0,0x1234), wr(1,0xABCD); done=1; words_loaded=2; cpu_reset falls on DONE.
//   Random rx_valid gaps and back-to-back bytes:
//     -> identical writes; exactly 1-cycle wr_en per word; rx_ready=0 during WRITE.
//   Length 0x1001 with ADDR_WIDTH=12:
//     -> ERR after LEN_LO; no wr_en; cpu_reset=1; error=1.
//   Stall for TIMEOUT_CYCLES (set 50) after first data byte:
//     -> ERR at cycle 50; words_loaded=0.
//   Assert rst mid-D_LO, then reload:
//     -> outputs return to reset values at once; subsequent full load succeeds.
//   EN only: correct data with checksum 0x0000 instead of 0xBE01:
//     -> error=1, done=0, both words written.

Source files
------------

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: receives a length-prefixed big-endian byte stream and writes Hack words to instruction memory.
// Define HACK_LOADER_CHECKSUM_EN to require a trailing 16-bit modulo-2^16 checksum of the data words.
module hack_rom_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [14:0]           wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_D_HI,
    S_D_LO,
    S_WRITE,
`ifdef HACK_LOADER_CHECKSUM_EN
    S_CK_HI,
    S_CK_LO,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  logic                  r_rx_ready;
  logic                  r_wr_en;
  logic [14:0]           r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_cpu_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [15:0]           r_len;
  logic [7:0]            r_hi;
  logic [TW-1:0]         r_tmo;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0]           r_sum;
  logic [7:0]            r_ck_hi;
`endif

  logic        w_accept;
  logic        w_tmo_hit;
  logic [15:0] w_len;
  logic [15:0] w_word;
  logic        w_more;

  assign w_accept  = rx_valid & r_rx_ready;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_len     = {r_len[15:8], rx_data};
  assign w_word    = {r_hi, rx_data};
  assign w_more    = (17'(r_words) < 17'(r_len));

  assign rx_ready     = r_rx_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

  // Loader FSM: all outputs are registered and updated together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 15'd0;
      r_wr_data   <= 16'd0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
      r_index     <= '0;
      r_len       <= 16'd0;
      r_hi        <= 8'd0;
      r_tmo       <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
      r_sum       <= 16'd0;
      r_ck_hi     <= 8'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;

      // Inter-byte timeout: only ticks while waiting for a byte; any other cycle restarts it.
      if (r_rx_ready && !w_accept) begin
        if (w_tmo_hit) begin
          r_state     <= S_ERR;
          r_rx_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_error     <= 1'b1;
          r_cpu_reset <= 1'b1;
          r_tmo       <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state     <= S_LEN_HI;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_index     <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
            r_sum       <= 16'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef HACK_LOADER_CHECKSUM_EN
              r_state <= S_CK_HI;
`else
              r_state     <= S_DONE;
              r_rx_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
`endif
            end else if (17'(w_len) > MAX_WORDS) begin
              r_state     <= S_ERR;
              r_rx_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
              r_cpu_reset <= 1'b1;
            end else begin
              r_state <= S_D_HI;
            end
          end
        end
        S_D_HI: begin
          if (w_accept) begin
            r_hi    <= rx_data;
            r_state <= S_D_LO;
          end
        end
        S_D_LO: begin
          if (w_accept) begin
            r_state    <= S_WRITE;
            r_rx_ready <= 1'b0;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= 15'(r_index);
            r_wr_data  <= w_word;
            r_words    <= r_words + 1'b1;
            r_index    <= r_index + 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + w_word;
`endif
          end
        end
        S_WRITE: begin
          if (w_more) begin
            r_state    <= S_D_HI;
            r_rx_ready <= 1'b1;
          end else begin
`ifdef HACK_LOADER_CHECKSUM_EN
            r_state    <= S_CK_HI;
            r_rx_ready <= 1'b1;
`else
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
`endif
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        S_CK_HI: begin
          if (w_accept) begin
            r_ck_hi <= rx_data;
            r_state <= S_CK_LO;
          end
        end
        S_CK_LO: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if ({r_ck_hi, rx_data} == r_sum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state     <= S_ERR;
              r_error     <= 1'b1;
              r_cpu_reset <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader (TIMEOUT_CYCLES=50); follows HACK_LOADER_CHECKSUM_EN if defined.
module tb_hack_rom_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en;
  logic [14:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int            n_checks = 0;
  int            n_pass = 0;
  int            wr_count = 0;
  logic [14:0]   log_addr [16];
  logic [15:0]   log_data [16];
  logic          prev_wr = 1'b0;

  hack_rom_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write-port monitor: logs every word and checks the strobe shape.
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_one_cycle", {31'd0, prev_wr}, 32'd0);
      check("rdy_in_write", {31'd0, rx_ready}, 32'd0);
      if (wr_count < 16) begin
        log_addr[wr_count] = wr_addr;
        log_data[wr_count] = wr_data;
      end
      wr_count++;
    end
    prev_wr = wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rdy_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input bit rnd);
    foreach (bytes[i]) send_byte(bytes[i], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [15:0] exp[$]);
    check({tag, "_count"}, wr_count, exp.size());
    foreach (exp[i]) begin
      if (i < 16) begin
        check($sformatf("%s_addr%0d", tag, i), {17'd0, log_addr[i]}, i);
        check($sformatf("%s_data%0d", tag, i), {16'd0, log_data[i]}, {16'd0, exp[i]});
      end
    end
  endtask

  task automatic check_done(input string tag, input int nw);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_words"}, {19'd0, words_loaded}, nw);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_error"}, {31'd0, error}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_wren"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_addr"}, {17'd0, wr_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, wr_data}, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_words"}, {19'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];

    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_rel");

    // Basic two-word load, with a start pulse mid-stream that must be ignored.
    wr_count = 0;
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cpurst", {31'd0, cpu_reset}, 32'd1);
    check("t1_rdy", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h00, 0);
    pulse_start();
    check("t1_ign_busy", {31'd0, busy}, 32'd1);
    q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stream(q, 1'b0);
    check("t1_wr_lat", {31'd0, wr_en}, 32'd1);
    check("t1_wr_data", {16'd0, wr_data}, 32'h0000ABCD);
`ifdef HACK_LOADER_CHECKSUM_EN
    q = '{8'hBE, 8'h01};
    send_stream(q, 1'b0);
`endif
    repeat (2) @(negedge clk);
    check_done("t1", 2);
    check_writes("t1", '{16'h1234, 16'hABCD});

    // Three words with random valid gaps.
    wr_count = 0;
    pulse_start();
    check("t2_cleared_done", {31'd0, done}, 32'd0);
    check("t2_cleared_words", {19'd0, words_loaded}, 32'd0);
    q = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h7F, 8'h00};
`ifdef HACK_LOADER_CHECKSUM_EN
    q.push_back(8'h7F);
    q.push_back(8'h00);
`endif
    send_stream(q, 1'b1);
    repeat (2) @(negedge clk);
    check_done("t2", 3);
    check_writes("t2", '{16'h0001, 16'hFFFF, 16'h7F00});

    // Oversized length is rejected right after LEN_LO.
    wr_count = 0;
    pulse_start();
    q = '{8'h10, 8'h01};
    send_stream(q, 1'b0);
    check_err("t3");
    repeat (3) @(negedge clk);
    check("t3_nowr", wr_count, 32'd0);

    // Zero-length load.
    wr_count = 0;
    pulse_start();
    check("t4_err_cleared", {31'd0, error}, 32'd0);
    q = '{8'h00, 8'h00};
`ifdef HACK_LOADER_CHECKSUM_EN
    q.push_back(8'h00);
    q.push_back(8'h00);
`endif
    send_stream(q, 1'b0);
    repeat (2) @(negedge clk);
    check_done("t4", 0);
    check("t4_nowr", wr_count, 32'd0);

    // Timeout after the first data byte.
    wr_count = 0;
    pulse_start();
    q = '{8'h00, 8'h01, 8'h12};
    send_stream(q, 1'b0);
    repeat (49) @(negedge clk);
    check("t5_busy49", {31'd0, busy}, 32'd1);
    check("t5_err49", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_err("t5");
    check("t5_words", {19'd0, words_loaded}, 32'd0);

    // Reset while waiting for a LO byte, then a full reload.
    wr_count = 0;
    pulse_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(q, 1'b0);
    check("t6_words_pre", {19'd0, words_loaded}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr_count = 0;
    pulse_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef HACK_LOADER_CHECKSUM_EN
    q.push_back(8'hBE);
    q.push_back(8'h01);
`endif
    send_stream(q, 1'b1);
    repeat (2) @(negedge clk);
    check_done("t6", 2);
    check_writes("t6", '{16'h1234, 16'hABCD});

`ifdef HACK_LOADER_CHECKSUM_EN
    // Wrong checksum: both words still written, load flagged as failed.
    wr_count = 0;
    pulse_start();
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
    send_stream(q, 1'b0);
    check_err("t7");
    check_writes("t7", '{16'h1234, 16'hABCD});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
